// File: rtl/stall_ctrl_gen.sv
// stall_ctrl_gen: pipeline stall / fetch-freeze controller.
// Detects load-use, branch and halt opcodes in decode and produces stall
// (pipeline registers) and stall_pm (PC / program memory) freeze signals.
// An external wait request holds everything in place while asserted.
// Optional build macro STALL_CTRL_PERF_EN adds perf_cnt, a saturating count
// of cycles with stall_pm asserted.
module stall_ctrl_gen #(
  parameter int               OP_W     = 6,
  parameter logic [OP_W-1:0]  LOAD_OP  = 6'b010100,
  parameter logic [OP_W-1:0]  BR_OP    = 6'b011110,
  parameter logic [OP_W-1:0]  HALT_OP  = 6'b010001,
  parameter int               LOAD_CYC = 2,
  parameter int               BR_CYC   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            ext_req,
  output logic            stall,
  output logic            stall_pm,
`ifdef STALL_CTRL_PERF_EN
  output logic [15:0]     perf_cnt,
`endif
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    BRANCH  = 3'd2,
    RELEASE = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Counter reload values: the state itself supplies one cycle, so load N-1.
  localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_CYC - 1);
  localparam logic [3:0] BR_RELOAD   = 4'(BR_CYC - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; an external wait request freezes state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ext_req) begin
      unique case (state_q)
        IDLE: begin
          if (op == HALT_OP) begin
            state_d = HALT;
          end else if (op == LOAD_OP) begin
            state_d = LOAD;
            cnt_d   = LOAD_RELOAD;
          end else if (op == BR_OP) begin
            state_d = BRANCH;
            cnt_d   = BR_RELOAD;
          end
        end
        LOAD, BRANCH: begin
          if (cnt_q == 4'd0) begin
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        RELEASE: begin
          state_d = IDLE;
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // Freeze outputs decoded from the registered state plus the wait request.
  always_comb begin
    stall    = (state_q == LOAD) || (state_q == HALT) || ext_req;
    stall_pm = (state_q == LOAD) || (state_q == BRANCH) ||
               (state_q == HALT) || ext_req;
    state_o  = state_q;
  end

`ifdef STALL_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Saturating increment for every cycle the fetch side is frozen.
  always_comb begin
    perf_d = perf_q;
    if (stall_pm && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Performance counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_q <= 16'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = perf_q;
`endif

endmodule
